// File: rtl/data_bus_arbiter_2x1.sv
// data_bus_arbiter_2x1
//   Shares one SRAM-like data port between two masters:
//     M0 = cached dcache refill/writeback path
//     M1 = uncached (conf) load/store path
//   Address handshakes are granted to one master at a time with round-robin
//   tie-breaking. The owner of every accepted request is pushed into an
//   in-order tag FIFO. Each s_data_ok/s_rdata is routed back to the owner
//   held at the FIFO head.
//
// Ports
//   clk, resetn                  core clock (rising edge), async active-low reset
//   mX_req/wr/size/addr/wdata    request from master X (held until mX_addr_ok)
//   mX_addr_ok                   master X request accepted this cycle
//   mX_data_ok, mX_rdata         response for master X (rdata valid with data_ok)
//   s_req/wr/size/addr/wdata     request to the wrapper, from the granted master
//   s_addr_ok                    wrapper accepted s_req
//   s_data_ok, s_rdata           wrapper response, strictly in acceptance order
//   err_orphan                   sticky: s_data_ok seen while no request was outstanding
module data_bus_arbiter_2x1 #(
  parameter int MAX_OUTST = 4,
  parameter int PTR_W     = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [1:0]  m0_size,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_addr_ok,
  output logic        m0_data_ok,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_addr_ok,
  output logic        m1_data_ok,
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  output logic        err_orphan
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(MAX_OUTST);

  state_t           state_reg, state_next;
  logic             grant_reg, grant_next;           // 0 = M0, 1 = M1
  logic             last_grant_reg, last_grant_next;
  logic             tag_mem [MAX_OUTST];             // owner id per outstanding request
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg, count_next;
  logic             err_orphan_reg;

  logic in_hold;
  logic accept;
  logic fifo_nonempty;
  logic pop;
  logic head;

  assign in_hold       = (state_reg == HOLD);
  // Gated only by the registered count, so a pop in the same cycle cannot
  // re-open the port combinationally.
  assign s_req         = in_hold && (count_reg < FULL_CNT);
  assign accept        = s_req && s_addr_ok;
  assign fifo_nonempty = (count_reg != '0);
  assign pop           = s_data_ok && fifo_nonempty;
  assign head          = tag_mem[rd_ptr_reg];

  // Request fields follow the registered grant; zero outside HOLD.
  assign s_wr    = in_hold && (grant_reg ? m1_wr : m0_wr);
  assign s_size  = in_hold ? (grant_reg ? m1_size  : m0_size)  : 2'b00;
  assign s_addr  = in_hold ? (grant_reg ? m1_addr  : m0_addr)  : 32'h0;
  assign s_wdata = in_hold ? (grant_reg ? m1_wdata : m0_wdata) : 32'h0;

  assign m0_addr_ok = accept && !grant_reg;
  assign m1_addr_ok = accept &&  grant_reg;

  assign m0_data_ok = pop && !head;
  assign m1_data_ok = pop &&  head;
  // With nothing outstanding the head slot is stale, so no master sees data.
  assign m0_rdata   = (fifo_nonempty && !head) ? s_rdata : 32'h0;
  assign m1_rdata   = (fifo_nonempty &&  head) ? s_rdata : 32'h0;

  assign err_orphan = err_orphan_reg;

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_next = HOLD;
          if (m0_req && m1_req) begin
            grant_next = ~last_grant_reg;
          end else begin
            grant_next = m1_req;
          end
        end
      end
      HOLD: begin
        // A raised request is never withdrawn, so HOLD only exits on acceptance.
        if (accept) begin
          state_next      = IDLE;
          last_grant_next = grant_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    case ({accept, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;   // M0 wins the first tie
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      err_orphan_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      count_reg      <= count_next;
      if (accept) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (s_data_ok && !fifo_nonempty) begin
        err_orphan_reg <= 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < MAX_OUTST; gi++) begin : g_tag
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          tag_mem[gi] <= 1'b0;
        end else if (accept && (wr_ptr_reg == PTR_W'(gi))) begin
          tag_mem[gi] <= grant_reg;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_data_bus_arbiter_2x1.sv
// Directed bench for data_bus_arbiter_2x1: a per-cycle vector table plus
// hand-written sequences for reset behaviour and FIFO clearing.
module tb_data_bus_arbiter_2x1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
  logic        s_req, s_wr;
  logic [1:0]  s_size;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        s_addr_ok, s_data_ok;
  logic        err_orphan;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_bus_arbiter_2x1 #(.MAX_OUTST(4), .PTR_W(2)) dut (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .err_orphan(err_orphan)
  );

  typedef struct {
    logic        m0_req;
    logic        m1_req;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        e_sreq;
    logic [31:0] e_addr;
    logic        e_m0a;
    logic        e_m1a;
    logic        e_m0d;
    logic        e_m1d;
    logic        e_err;
  } vec_t;

  localparam int NV = 28;
  vec_t tbl [NV];

  function automatic vec_t v(logic a0, logic a1, logic aok, logic dok, logic [31:0] rd,
                             logic sr, logic [31:0] ad, logic e0a, logic e1a,
                             logic e0d, logic e1d, logic er);
    vec_t r;
    r.m0_req = a0;  r.m1_req = a1;  r.aok = aok;  r.dok = dok;  r.rdata = rd;
    r.e_sreq = sr;  r.e_addr = ad;  r.e_m0a = e0a; r.e_m1a = e1a;
    r.e_m0d = e0d;  r.e_m1d = e1d;  r.e_err = er;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_wdata;
    logic [1:0]  exp_size;
    logic        exp_wr;

    // Fixed master request fields.
    m0_wr = 1'b0; m0_size = 2'd2; m0_addr = 32'h0000_1000; m0_wdata = 32'hA0A0_A0A0;
    m1_wr = 1'b1; m1_size = 2'd1; m1_addr = 32'h0000_2000; m1_wdata = 32'hB1B1_B1B1;
    m0_req = 1'b0; m1_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = 32'h0;
    resetn = 1'b0;

    //                m0 m1 aok dok rdata          sreq addr           m0a m1a m0d m1d err
    // M0 read alone, response three cycles after acceptance
    tbl[0]  = v(1, 0, 0, 0, 32'h0,           0, 32'h0,      0, 0, 0, 0, 0);
    tbl[1]  = v(1, 0, 1, 0, 32'h0,           1, 32'h1000,   1, 0, 0, 0, 0);
    tbl[2]  = v(0, 0, 0, 0, 32'h0,           0, 32'h0,      0, 0, 0, 0, 0);
    tbl[3]  = v(0, 0, 0, 0, 32'h0,           0, 32'h0,      0, 0, 0, 0, 0);
    tbl[4]  = v(0, 0, 0, 1, 32'hDEAD_BEEF,   0, 32'h0,      0, 0, 1, 0, 0);
    // Both request every cycle: grants alternate (M0 was last, so M1 first)
    tbl[5]  = v(1, 1, 1, 0, 32'h0,           0, 32'h0,      0, 0, 0, 0, 0);
    tbl[6]  = v(1, 1, 1, 0, 32'h0,           1, 32'h2000,   0, 1, 0, 0, 0);
    tbl[7]  = v(1, 1, 1, 0, 32'h0,           0, 32'h0,      0, 0, 0, 0, 0);
    tbl[8]  = v(1, 1, 1, 0, 32'h0,           1, 32'h1000,   1, 0, 0, 0, 0);
    tbl[9]  = v(1, 1, 1, 0, 32'h0,           0, 32'h0,      0, 0, 0, 0, 0);
    tbl[10] = v(1, 1, 1, 0, 32'h0,           1, 32'h2000,   0, 1, 0, 0, 0);
    tbl[11] = v(1, 1, 1, 0, 32'h0,           0, 32'h0,      0, 0, 0, 0, 0);
    tbl[12] = v(1, 1, 1, 0, 32'h0,           1, 32'h1000,   1, 0, 0, 0, 0);
    // FIFO full (owners M1,M0,M1,M0): s_req held low in HOLD, even on a pop
    tbl[13] = v(1, 1, 1, 0, 32'h0,           0, 32'h0,      0, 0, 0, 0, 0);
    tbl[14] = v(1, 1, 1, 0, 32'h0,           0, 32'h2000,   0, 0, 0, 0, 0);
    tbl[15] = v(1, 1, 1, 1, 32'h1111_1111,   0, 32'h2000,   0, 0, 0, 1, 0);
    // s_req back; push+pop in the same cycle at count 3
    tbl[16] = v(1, 1, 1, 1, 32'h2222_2222,   1, 32'h2000,   0, 1, 1, 0, 0);
    tbl[17] = v(0, 0, 0, 1, 32'h3333_3333,   0, 32'h0,      0, 0, 0, 1, 0);
    // M0 granted, s_addr_ok withheld; M1 request ignored meanwhile
    tbl[18] = v(1, 0, 0, 0, 32'h0,           0, 32'h0,      0, 0, 0, 0, 0);
    tbl[19] = v(1, 1, 0, 0, 32'h0,           1, 32'h1000,   0, 0, 0, 0, 0);
    tbl[20] = v(1, 1, 0, 0, 32'h0,           1, 32'h1000,   0, 0, 0, 0, 0);
    tbl[21] = v(1, 1, 0, 0, 32'h0,           1, 32'h1000,   0, 0, 0, 0, 0);
    tbl[22] = v(1, 1, 0, 0, 32'h0,           1, 32'h1000,   0, 0, 0, 0, 0);
    // Push+pop at count 2, then drain
    tbl[23] = v(1, 1, 1, 1, 32'h4444_4444,   1, 32'h1000,   1, 0, 1, 0, 0);
    tbl[24] = v(0, 0, 0, 1, 32'h5555_5555,   0, 32'h0,      0, 0, 0, 1, 0);
    tbl[25] = v(0, 0, 0, 1, 32'h6666_6666,   0, 32'h0,      0, 0, 1, 0, 0);
    // Orphan response: dropped, error flag visible next cycle
    tbl[26] = v(0, 0, 0, 1, 32'h0,           0, 32'h0,      0, 0, 0, 0, 0);
    tbl[27] = v(0, 0, 0, 0, 32'h0,           0, 32'h0,      0, 0, 0, 0, 1);

    // Reset state
    #12;
    chk("reset s_req", 32'(s_req), 32'h0);
    chk("reset s_addr", s_addr, 32'h0);
    chk("reset m0_addr_ok", 32'(m0_addr_ok), 32'h0);
    chk("reset m1_data_ok", 32'(m1_data_ok), 32'h0);
    chk("reset err_orphan", 32'(err_orphan), 32'h0);
    resetn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      m0_req    = tbl[i].m0_req;
      m1_req    = tbl[i].m1_req;
      s_addr_ok = tbl[i].aok;
      s_data_ok = tbl[i].dok;
      s_rdata   = tbl[i].rdata;
      @(negedge clk);
      exp_wr    = (tbl[i].e_addr == 32'h2000);
      exp_size  = (tbl[i].e_addr == 32'h1000) ? 2'd2 : (tbl[i].e_addr == 32'h2000) ? 2'd1 : 2'd0;
      exp_wdata = (tbl[i].e_addr == 32'h1000) ? 32'hA0A0_A0A0 :
                  (tbl[i].e_addr == 32'h2000) ? 32'hB1B1_B1B1 : 32'h0;
      $display("row %0d: s_req=%0b s_addr=%h aok=%0b/%0b dok=%0b/%0b err=%0b", i, s_req, s_addr,
               m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok, err_orphan);
      chk($sformatf("row%0d s_req", i), 32'(s_req), 32'(tbl[i].e_sreq));
      chk($sformatf("row%0d s_addr", i), s_addr, tbl[i].e_addr);
      chk($sformatf("row%0d s_wr", i), 32'(s_wr), 32'(exp_wr));
      chk($sformatf("row%0d s_size", i), 32'(s_size), 32'(exp_size));
      chk($sformatf("row%0d s_wdata", i), s_wdata, exp_wdata);
      chk($sformatf("row%0d m0_addr_ok", i), 32'(m0_addr_ok), 32'(tbl[i].e_m0a));
      chk($sformatf("row%0d m1_addr_ok", i), 32'(m1_addr_ok), 32'(tbl[i].e_m1a));
      chk($sformatf("row%0d m0_data_ok", i), 32'(m0_data_ok), 32'(tbl[i].e_m0d));
      chk($sformatf("row%0d m1_data_ok", i), 32'(m1_data_ok), 32'(tbl[i].e_m1d));
      chk($sformatf("row%0d m0_rdata", i), m0_rdata, tbl[i].e_m0d ? tbl[i].rdata : 32'h0);
      chk($sformatf("row%0d m1_rdata", i), m1_rdata, tbl[i].e_m1d ? tbl[i].rdata : 32'h0);
      chk($sformatf("row%0d err_orphan", i), 32'(err_orphan), 32'(tbl[i].e_err));
    end

    // Accept one M1 request so the FIFO is non-empty, then reset mid-HOLD on M0.
    @(posedge clk); #1;
    m1_req = 1'b1; m0_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = 32'h0;
    @(negedge clk);
    $display("seq m1 request raised");
    chk("seq idle s_req", 32'(s_req), 32'h0);
    @(posedge clk); #1;
    s_addr_ok = 1'b1;
    @(negedge clk);
    $display("seq m1 accepted");
    chk("seq m1 s_req", 32'(s_req), 32'h1);
    chk("seq m1 addr_ok", 32'(m1_addr_ok), 32'h1);
    chk("seq m1 s_wdata", s_wdata, 32'hB1B1_B1B1);
    @(posedge clk); #1;
    m1_req = 1'b0; s_addr_ok = 1'b0; m0_req = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    $display("seq m0 in HOLD before reset");
    chk("seq m0 hold s_req", 32'(s_req), 32'h1);
    chk("seq m0 hold s_addr", s_addr, 32'h1000);
    #2;
    resetn = 1'b0;
    s_addr_ok = 1'b1;
    #1;
    $display("seq reset asserted mid-HOLD");
    chk("midreset s_req", 32'(s_req), 32'h0);
    chk("midreset s_addr", s_addr, 32'h0);
    chk("midreset s_wdata", s_wdata, 32'h0);
    chk("midreset m0_addr_ok", 32'(m0_addr_ok), 32'h0);
    chk("midreset err_orphan", 32'(err_orphan), 32'h0);
    @(posedge clk); #2;
    resetn = 1'b1;
    m0_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1; s_rdata = 32'h0;
    @(negedge clk);
    $display("seq late response after reset");
    chk("postreset m0_data_ok", 32'(m0_data_ok), 32'h0);
    chk("postreset m1_data_ok", 32'(m1_data_ok), 32'h0);
    @(posedge clk); #1;
    s_data_ok = 1'b0;
    @(negedge clk);
    $display("seq orphan flag after reset");
    chk("postreset err_orphan", 32'(err_orphan), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
